regfile_wr_arbiter: RTL and testbench

- Owns the single write port of the 32x32 integer register file. It shares that port between three sources: core writeback, a debug/loader write channel with a valid/ready handshake, and a hardware clear sequencer that zeroes x1..x31.
- It sits between the writeback stage and the register file's rd write inputs.
- Core writeback is combinational pass-through, so the single-cycle core still writes on the same clock edge.

---
 rtl/regfile_wr_arbiter_if.sv | 36 +++
 rtl/regfile_wr_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Write-port arbiter bundle: core writeback, debug handshake, clear control and
// the register file rd write port. Signal prefixes are from the arbiter's side.
interface regfile_wr_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              i_core_wren;
  logic [REG_AW-1:0] i_core_addr;
  logic [XLEN-1:0]   i_core_data;
  logic              i_dbg_valid;
  logic [REG_AW-1:0] i_dbg_addr;
  logic [XLEN-1:0]   i_dbg_data;
  logic              o_dbg_ready;
  logic              i_clr_req;
  logic              o_clr_busy;
  logic              o_clr_done;
  logic              o_core_stall;
  logic              o_core_drop;
  logic              o_rd_wren;
  logic [REG_AW-1:0] o_rd_addr;
  logic [XLEN-1:0]   o_rd_data;

  modport slave (
    input  i_core_wren, i_core_addr, i_core_data,
    input  i_dbg_valid, i_dbg_addr, i_dbg_data, i_clr_req,
    output o_dbg_ready, o_clr_busy, o_clr_done, o_core_stall, o_core_drop,
    output o_rd_wren, o_rd_addr, o_rd_data
  );

  modport master (
    output i_core_wren, i_core_addr, i_core_data,
    output i_dbg_valid, i_dbg_addr, i_dbg_data, i_clr_req,
    input  o_dbg_ready, o_clr_busy, o_clr_done, o_core_stall, o_core_drop,
    input  o_rd_wren, o_rd_addr, o_rd_data
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between core writeback (combinational
// pass-through), a one-entry debug buffer and a x1..x31 clear sweep.
module regfile_wr_arbiter #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  regfile_wr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  typedef struct packed {
    logic              wren;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_t;

  localparam logic [REG_AW-1:0] LAST_IDX  = '1;
  localparam logic [REG_AW-1:0] FIRST_IDX = REG_AW'(1);

  state_t            r_state, w_nxt;
  logic [REG_AW-1:0] r_idx;
  logic              r_buf_vld;
  logic [REG_AW-1:0] r_buf_addr;
  logic [XLEN-1:0]   r_buf_data;
  logic              r_drop;
  wr_t               w_sel;
  logic              w_drain;
  logic              w_port_open;

  assign w_port_open = (r_state == S_IDLE) || (r_state == S_DONE);

  always_comb begin
    w_nxt   = r_state;
    w_sel   = '0;
    w_drain = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.i_clr_req) w_nxt = S_CLEAR;
      S_CLEAR: if (r_idx == LAST_IDX) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (w_port_open && bus.i_core_wren) begin
      w_sel = '{wren: 1'b1, addr: bus.i_core_addr, data: bus.i_core_data};
    end else if (r_state == S_CLEAR) begin
      w_sel = '{wren: 1'b1, addr: r_idx, data: '0};
    end else if (w_port_open && r_buf_vld) begin
      w_sel   = '{wren: 1'b1, addr: r_buf_addr, data: r_buf_data};
      w_drain = 1'b1;
    end
  end

  // x0 is hardwired zero: the slot is still consumed, only the strobe is masked.
  // Reset also masks the strobe since core writeback bypasses the registers.
  assign bus.o_rd_wren    = w_sel.wren && (w_sel.addr != '0) && i_rst;
  assign bus.o_rd_addr    = w_sel.addr;
  assign bus.o_rd_data    = w_sel.data;
  assign bus.o_dbg_ready  = !r_buf_vld;
  assign bus.o_clr_busy   = (r_state == S_CLEAR);
  assign bus.o_core_stall = (r_state == S_CLEAR);
  assign bus.o_clr_done   = (r_state == S_DONE);
  assign bus.o_core_drop  = r_drop;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= FIRST_IDX;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_CLEAR) r_idx <= (r_idx == LAST_IDX) ? FIRST_IDX : r_idx + 1'b1;
      if (r_state == S_IDLE && bus.i_clr_req)       r_drop <= 1'b0;
      else if (r_state == S_CLEAR && bus.i_core_wren) r_drop <= 1'b1;
    end
  end

  // Drain wins over accept; ready is low while full so both never coincide.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_buf_vld  <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
    end else if (w_drain) begin
      r_buf_vld  <= 1'b0;
    end else if (bus.i_dbg_valid && !r_buf_vld) begin
      r_buf_vld  <= 1'b1;
      r_buf_addr <= bus.i_dbg_addr;
      r_buf_data <= bus.i_dbg_data;
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: passthrough, debug buffer, clear sweep
// and mid-sweep reset, with hand-computed expectations.
module tb_regfile_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  regfile_wr_arbiter_if #(.XLEN(32), .REG_AW(5)) bus ();

  regfile_wr_arbiter #(.XLEN(32), .REG_AW(5)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.i_core_wren = en;
    bus.i_core_addr = a;
    bus.i_core_data = d;
  endtask

  task automatic dbg(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.i_dbg_valid = v;
    bus.i_dbg_addr  = a;
    bus.i_dbg_data  = d;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".wren"}, 32'(bus.o_rd_wren), 32'(en));
    if (en) begin
      chk({tag, ".addr"}, 32'(bus.o_rd_addr), 32'(a));
      chk({tag, ".data"}, bus.o_rd_data, d);
    end
  endtask

  initial begin
    core(1'b1, 5'd4, 32'h1);
    dbg(1'b0, 5'd0, 32'h0);
    bus.i_clr_req = 1'b0;
    #3;
    chk("rst.ready", 32'(bus.o_dbg_ready), 32'd1);
    chk("rst.busy",  32'(bus.o_clr_busy), 32'd0);
    chk("rst.done",  32'(bus.o_clr_done), 32'd0);
    chk("rst.stall", 32'(bus.o_core_stall), 32'd0);
    chk("rst.drop",  32'(bus.o_core_drop), 32'd0);
    chk("rst.wren",  32'(bus.o_rd_wren), 32'd0);
    core(1'b0, 5'd0, 32'h0);
    #9 rst_n = 1'b1;
    tick();

    // core passthrough
    core(1'b1, 5'd5, 32'hDEADBEEF); #1;
    chk_wr("core5", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    core(1'b1, 5'd0, 32'h1234); #1;
    chk_wr("core0", 1'b0, 5'd0, 32'h0);
    tick();
    core(1'b0, 5'd0, 32'h0);

    // debug write with a second request held off
    dbg(1'b1, 5'd7, 32'hA5A5A5A5); #1;
    chk("dbg7.ready0", 32'(bus.o_dbg_ready), 32'd1);
    chk_wr("dbg7.pre", 1'b0, 5'd0, 32'h0);
    tick();
    dbg(1'b1, 5'd8, 32'h88); #1;
    chk("dbg7.ready1", 32'(bus.o_dbg_ready), 32'd0);
    chk_wr("dbg7.wr", 1'b1, 5'd7, 32'hA5A5A5A5);
    tick();
    chk("dbg8.ready0", 32'(bus.o_dbg_ready), 32'd1);
    chk_wr("dbg8.pre", 1'b0, 5'd0, 32'h0);
    tick();
    dbg(1'b0, 5'd0, 32'h0); #1;
    chk("dbg8.ready1", 32'(bus.o_dbg_ready), 32'd0);
    chk_wr("dbg8.wr", 1'b1, 5'd8, 32'h88);
    tick();
    chk("dbg8.ready2", 32'(bus.o_dbg_ready), 32'd1);

    // debug starved by four core writes
    dbg(1'b1, 5'd3, 32'h11);
    core(1'b1, 5'd10, 32'd100); #1;
    chk_wr("starve.c0", 1'b1, 5'd10, 32'd100);
    tick();
    dbg(1'b0, 5'd0, 32'h0);
    for (int i = 1; i < 4; i++) begin
      core(1'b1, 5'(10 + i), 32'(100 + i)); #1;
      chk_wr($sformatf("starve.c%0d", i), 1'b1, 5'(10 + i), 32'(100 + i));
      chk($sformatf("starve.rdy%0d", i), 32'(bus.o_dbg_ready), 32'd0);
      tick();
    end
    core(1'b0, 5'd0, 32'h0); #1;
    chk_wr("starve.dbg", 1'b1, 5'd3, 32'h11);
    tick();
    chk("starve.ready", 32'(bus.o_dbg_ready), 32'd1);

    // clear sweep started together with a core write
    bus.i_clr_req = 1'b1;
    core(1'b1, 5'd20, 32'h20); #1;
    chk_wr("clr.core", 1'b1, 5'd20, 32'h20);
    chk("clr.busy0", 32'(bus.o_clr_busy), 32'd0);
    tick();
    bus.i_clr_req = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      if (i == 5) core(1'b1, 5'd6, 32'hFFFF);
      else        core(1'b0, 5'd0, 32'h0);
      #1;
      chk_wr($sformatf("clr.x%0d", i), 1'b1, 5'(i), 32'h0);
      chk($sformatf("clr.busy%0d", i), 32'(bus.o_clr_busy), 32'd1);
      chk($sformatf("clr.stall%0d", i), 32'(bus.o_core_stall), 32'd1);
      chk($sformatf("clr.done%0d", i), 32'(bus.o_clr_done), 32'd0);
      tick();
    end
    core(1'b0, 5'd0, 32'h0); #1;
    chk("clr.done", 32'(bus.o_clr_done), 32'd1);
    chk("clr.busyD", 32'(bus.o_clr_busy), 32'd0);
    chk("clr.stallD", 32'(bus.o_core_stall), 32'd0);
    chk("clr.drop", 32'(bus.o_core_drop), 32'd1);
    chk_wr("clr.idleD", 1'b0, 5'd0, 32'h0);
    tick();
    chk("clr.done1", 32'(bus.o_clr_done), 32'd0);
    chk("clr.drop1", 32'(bus.o_core_drop), 32'd1);

    // debug entry accepted on the edge the sweep starts survives the clear
    bus.i_clr_req = 1'b1;
    dbg(1'b1, 5'd9, 32'h55); #1;
    chk_wr("keep.pre", 1'b0, 5'd0, 32'h0);
    tick();
    bus.i_clr_req = 1'b0;
    dbg(1'b0, 5'd0, 32'h0); #1;
    chk("keep.drop", 32'(bus.o_core_drop), 32'd0);
    chk("keep.ready", 32'(bus.o_dbg_ready), 32'd0);
    for (int i = 1; i <= 31; i++) begin
      chk_wr($sformatf("keep.x%0d", i), 1'b1, 5'(i), 32'h0);
      tick();
    end
    chk("keep.done", 32'(bus.o_clr_done), 32'd1);
    chk_wr("keep.x9", 1'b1, 5'd9, 32'h55);
    tick();
    chk("keep.ready1", 32'(bus.o_dbg_ready), 32'd1);
    chk_wr("keep.idle", 1'b0, 5'd0, 32'h0);

    // reset in the middle of a sweep
    bus.i_clr_req = 1'b1;
    tick();
    bus.i_clr_req = 1'b0;
    for (int i = 1; i < 12; i++) tick();
    chk_wr("abort.x12", 1'b1, 5'd12, 32'h0);
    rst_n = 1'b0; #1;
    chk("abort.busy", 32'(bus.o_clr_busy), 32'd0);
    chk("abort.stall", 32'(bus.o_core_stall), 32'd0);
    chk("abort.wren", 32'(bus.o_rd_wren), 32'd0);
    chk("abort.done", 32'(bus.o_clr_done), 32'd0);
    chk("abort.ready", 32'(bus.o_dbg_ready), 32'd1);
    tick();
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort.nodone%0d", i), 32'(bus.o_clr_done), 32'd0);
      tick();
    end
    bus.i_clr_req = 1'b1;
    tick();
    bus.i_clr_req = 1'b0; #1;
    chk_wr("restart.x1", 1'b1, 5'd1, 32'h0);
    chk("restart.busy", 32'(bus.o_clr_busy), 32'd1);
    tick();
    chk_wr("restart.x2", 1'b1, 5'd2, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
